// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared ICache geometry, AXI constants and the
// refill engine state encoding.
package icache_refill_pkg;

    localparam int INDEX_SIZE_I    = 7;
    localparam int TAG_SIZE_I      = 21;
    localparam int WORD_OFF_SIZE_I = 2;
    localparam int WORDS_I         = 1 << WORD_OFF_SIZE_I;
    localparam int AXI_ID_I        = 0;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_WR   = 2'd3
    } state_e;

endpackage

// File: rtl/icache_refill_if.sv
// icache_refill_if: AXI4 read address + read data channels.
// master = refill engine, slave = memory side.
interface icache_refill_if;
    import icache_refill_pkg::*;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arid;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst, arid, rready,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
        output arready, rvalid, rdata, rresp, rlast
    );

endinterface

// File: rtl/icache_line_buffer.sv
// icache_line_buffer: WORDS x 32 beat collector for one cache line.
// Ports: clr_i zeroes all words, we_i/idx_i/data_i write one word,
// line_o is the flat line (word 0 in the low bits).
module icache_line_buffer #(
    parameter int WORDS = 4,
    parameter int IW    = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [IW-1:0]       idx_i,
    input  logic [31:0]         data_i,
    output logic [32*WORDS-1:0] line_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (!resetn || clr_i) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= data_i;
        end
    end

    always_comb begin
        line_o = '0;
        for (int i = 0; i < WORDS; i++) begin
            line_o[i*32 +: 32] = mem_q[i];
        end
    end

endmodule

// File: rtl/icache_refill.sv
// icache_refill: ICache line-refill engine. Fetches one line per miss
// with an AXI4 INCR burst, writes data/tag/valid in one cycle, and
// services single-line invalidates (deferred while busy).
// Ports: miss_req_i/miss_addr_i, inv_req_i/inv_index_i from control;
// busy_o, refill_done_o, refill_err_o back; axi = AXI read master;
// ram_* = cache RAM write port.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int INDEX_SIZE    = INDEX_SIZE_I,
    parameter int TAG_SIZE      = TAG_SIZE_I,
    parameter int WORD_OFF_SIZE = WORD_OFF_SIZE_I,
    parameter int AXI_ID        = AXI_ID_I
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    miss_req_i,
    input  logic [31:0]             miss_addr_i,
    input  logic                    inv_req_i,
    input  logic [INDEX_SIZE-1:0]   inv_index_i,
    output logic                    busy_o,
    output logic                    refill_done_o,
    output logic                    refill_err_o,
    icache_refill_if.master         axi,
    output logic [INDEX_SIZE-1:0]   ram_a_o,
    output logic [TAG_SIZE-1:0]     ram_d_o,
    output logic [32*(1<<WORD_OFF_SIZE)-1:0] ram_dina_o,
    output logic [4*(1<<WORD_OFF_SIZE)-1:0]  ram_wen_o,
    output logic                    ram_wen_v_o,
    output logic                    ram_w_valid_o
);

    localparam int WORDS = 1 << WORD_OFF_SIZE;
    localparam int OFF   = WORD_OFF_SIZE + 2;
    // One extra bit so an overlong burst saturates instead of wrapping.
    localparam int CW    = WORD_OFF_SIZE + 1;

    state_e                  state_q, state_d;
    logic [TAG_SIZE-1:0]     tag_q, tag_d;
    logic [INDEX_SIZE-1:0]   idx_q, idx_d;
    logic [31:0]             addr_q, addr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    pend_q, pend_d;
    logic [INDEX_SIZE-1:0]   pidx_q, pidx_d;
    logic                    post_q, post_d;
    logic                    buf_clr;
    logic                    buf_we;
    logic [32*WORDS-1:0]     line;
    logic                    last_pos;

    assign axi.arlen   = 8'(WORDS - 1);
    assign axi.arsize  = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arid    = 4'(AXI_ID);
    assign axi.araddr  = addr_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign last_pos    = (cnt_q == CW'(WORDS - 1));

    icache_line_buffer #(
        .WORDS (WORDS),
        .IW    (WORD_OFF_SIZE)
    ) u_buf (
        .clk    (clk),
        .resetn (resetn),
        .clr_i  (buf_clr),
        .we_i   (buf_we),
        .idx_i  (cnt_q[WORD_OFF_SIZE-1:0]),
        .data_i (axi.rdata),
        .line_o (line)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
            post_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            post_q  <= post_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        pend_d        = pend_q;
        pidx_d        = pidx_q;
        post_d        = 1'b0;
        buf_clr       = 1'b0;
        buf_we        = 1'b0;
        axi.arvalid   = 1'b0;
        axi.rready    = 1'b0;
        refill_done_o = 1'b0;
        refill_err_o  = 1'b0;
        ram_a_o       = '0;
        ram_d_o       = '0;
        ram_dina_o    = '0;
        ram_wen_o     = '0;
        ram_wen_v_o   = 1'b0;
        ram_w_valid_o = 1'b0;

        // Invalidates arriving while busy are parked; newest wins.
        if (busy_o && inv_req_i) begin
            pend_d = 1'b1;
            pidx_d = inv_index_i;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    ram_a_o     = pidx_q;
                    ram_wen_v_o = 1'b1;
                    pend_d      = inv_req_i;
                    if (inv_req_i) begin
                        pidx_d = inv_index_i;
                    end
                end else if (inv_req_i) begin
                    ram_a_o     = inv_index_i;
                    ram_wen_v_o = 1'b1;
                end else if (miss_req_i && !post_q) begin
                    // post_q masks the stale miss_req seen right after WR.
                    tag_d   = miss_addr_i[31 -: TAG_SIZE];
                    idx_d   = miss_addr_i[OFF +: INDEX_SIZE];
                    addr_d  = {miss_addr_i[31:OFF], {OFF{1'b0}}};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    buf_clr = 1'b1;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) begin
                    cnt_d   = '0;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                axi.rready = 1'b1;
                if (axi.rvalid) begin
                    buf_we = !cnt_q[CW-1];
                    if (cnt_q != CW'(WORDS)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    // A bad response or rlast off the final beat
                    // both poison the line.
                    if (axi.rresp != AXI_RESP_OKAY ||
                        axi.rlast != last_pos) begin
                        err_d = 1'b1;
                    end
                    if (axi.rlast) begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                ram_a_o       = idx_q;
                ram_d_o       = tag_q;
                ram_dina_o    = line;
                ram_wen_o     = '1;
                ram_wen_v_o   = 1'b1;
                ram_w_valid_o = !err_q;
                refill_done_o = 1'b1;
                refill_err_o  = err_q;
                post_d        = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Line-refill engine for the instruction cache: the writer side of the ICache tag/data/valid RAM.
- On a miss it issues one AXI4 INCR read burst for the aligned line and collects the returned beats into a line buffer.
- It then writes data, tag and valid into the cache RAM in one cycle and pulses refill_done to the ICache control FSM.
- It also services single-line invalidate requests.

Parameters:
- INDEX_SIZE, 7, line index bits (128 lines).
- TAG_SIZE, 21, tag bits; INDEX_SIZE + WORD_OFF_SIZE + 2 + TAG_SIZE = 32.
- WORD_OFF_SIZE, 2, word-in-line bits; WORDS = 2**WORD_OFF_SIZE.
- AXI_ID, 0, constant arid value.

Ports:
- clk, in, 1, clock.
- resetn, in, 1, synchronous active-low reset.
- miss_req, in, 1, level request from ICache control; held until refill_done.
- miss_addr, in, 32, miss PC; must be stable while miss_req is high.
- inv_req, in, 1, one-cycle invalidate request.
- inv_index, in, INDEX_SIZE, line to invalidate.
- busy, out, 1, engine not in IDLE.
- refill_done, out, 1, one-cycle pulse; line written.
- refill_err, out, 1, one-cycle pulse with refill_done if any rresp != OKAY.
- arvalid, out, 1, AXI read address valid.
- arready, in, 1, AXI read address ready.
- araddr, out, 32, line-aligned address.
- arlen, out, 8, WORDS-1.
- arsize, out, 3, 3'b010.
- arburst, out, 2, 2'b01 (INCR).
- arid, out, 4, AXI_ID.
- rvalid, in, 1, AXI read data valid.
- rready, out, 1, AXI read data ready.
- rdata, in, 32, beat data.
- rresp, in, 2, beat response.
- rlast, in, 1, last beat.
- ram_a, out, INDEX_SIZE, RAM write index.
- ram_d, out, TAG_SIZE, RAM write tag.
- ram_dina, out, 32*WORDS, RAM write line.
- ram_wen, out, 4*WORDS, per-byte write enables.
- ram_wen_v, out, 1, valid-bit write enable.
- ram_w_valid, out, 1, valid value to write.

Behaviour:
- Reset (resetn=0 at posedge): state IDLE; all outputs 0 except arsize/arburst/arlen/arid, which are constants; beat counter 0; error flag 0.
- Reset mid-burst: state and counter are discarded and the AXI slave is reset alongside (same resetn). No RAM write occurs after reset.
- States: IDLE, AR, R, WR.
- IDLE:
  - inv_req=1 has priority. In the same cycle drive ram_a=inv_index, ram_wen_v=1, ram_w_valid=0, ram_wen=0; stay in IDLE.
  - Else miss_req=1: latch tag = miss_addr[31 -: TAG_SIZE] and index; araddr = miss_addr with the low WORD_OFF_SIZE+2 bits cleared; go to AR.
- AR: arvalid=1 held until arready; arvalid and araddr must not change while waiting. On handshake go to R with counter 0.
- R:
  - rready=1.
  - Each rvalid beat stores rdata into buffer word[counter], increments counter, and ORs (rresp != 0) into the error flag.
  - On rlast with rvalid go to WR.
  - rlast on the wrong beat: a line is still written with the beats received; unfilled words are 0 and refill_err=1.
- WR (one cycle): ram_a=index, ram_d=tag, ram_dina=buffer, ram_wen=all 1s, ram_wen_v=1, ram_w_valid=!err; refill_done=1, refill_err=err; go to IDLE.
- An erroneous line is written invalid, so the next fetch misses again.
- inv_req while busy: latched into a one-entry pending register; serviced in the first IDLE cycle before any new miss. A second inv_req while pending overwrites the first.
- A pending invalidate to the same index as a just-completed refill executes, leaving the line invalid.
- miss_req may still be high in the cycle after refill_done. The control FSM drops it that cycle; the engine ignores miss_req in the cycle following WR, so there is no double refill.
- Latency miss_req→refill_done with zero-wait AXI: 1 (IDLE) + 1 (AR) + WORDS (R) + 1 (WR) = WORDS+3 cycles.
- ram_* outputs are registered-free combinational decodes of state; ram_wen=0 outside WR.

Decomposition:
- Shared package/define file (extends the existing cache define file): INDEX_SIZE_I, TAG_SIZE_I, WORD_OFF_SIZE_I, AXI burst/size/resp constants, state encoding localparams.
- One sub-module, icache_line_buffer: a WORDS×32 register array with a write port (index, data, we), a clear on refill start, and a flat 32*WORDS read bus.

Test Plan:
- Miss at 0x1FC0_0014, zero-wait slave returning 0xA0..0xA3 → araddr=0x1FC0_0010, arlen=3; in WR, ram_a=0x001, ram_dina={A3,A2,A1,A0}, ram_wen=16'hFFFF, ram_w_valid=1; refill_done at cycle 7.
- arready delayed 5 cycles, rvalid gaps of 2 cycles between beats → arvalid/araddr stable while waiting; same line written; refill_done once.
- Beat 2 with rresp=2'b10 → refill_err=1 with refill_done; ram_w_valid=0.
- inv_req index 5 in IDLE → same cycle ram_wen_v=1, ram_w_valid=0, ram_a=5, ram_wen=0. Same during R → executed the cycle after refill_done.
- Reset asserted during beat 1 → next cycle IDLE, all handshake outputs 0, no ram_wen; a new miss completes normally.
- miss_req held 1 cycle past refill_done → no second arvalid.
